// File: rtl/pe_conv1d_pkg.sv
// Shared types for the 1-D convolution processing element.
// Holds the FSM state encoding and the latched job configuration.
package pe_conv1d_pkg;

  localparam int CFG_FILTER_MAX  = 8;
  localparam int CFG_IFMAP_DEPTH = 16;
  localparam int CFG_NUM_FILT    = 2;

  localparam int CFG_FS_W  = $clog2(CFG_FILTER_MAX + 1);
  localparam int CFG_LEN_W = $clog2(CFG_IFMAP_DEPTH + 1);
  localparam int CFG_NF_W  = $clog2(CFG_NUM_FILT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FILT,
    LOAD_IFMAP,
    MAC,
    ACC_PSUM,
    EMIT,
    FIN
  } state_e;

  typedef struct packed {
    logic [CFG_FS_W-1:0]  filter_size;
    logic [CFG_LEN_W-1:0] ifmap_len;
    logic [CFG_LEN_W-1:0] stride;
    logic [CFG_NF_W-1:0]  num_filt;
  } cfg_t;

endpackage

// File: rtl/pe_mac_unit.sv
// Signed multiplier feeding a wrapping accumulator register.
// add_psum swaps the product for an external partial sum.
module pe_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     add_psum,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  psum,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    addend;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;

  // next accumulator: clear restarts from the current term
  always_comb begin
    prod     = a * b;
    prod_ext = ACC_W'(prod);
    base     = clr ? '0 : acc_q;
    addend   = add_psum ? psum : prod_ext;
    acc_d    = en ? base + addend : acc_q;
  end

  // accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/pe_conv1d_mc.sv
// 1-D multi-channel convolution PE with filter/ifmap scratchpads.
// Define PE_CONV1D_PSUM_IN_EN to add incoming psums per result.
module pe_conv1d_mc
  import pe_conv1d_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 20,
  parameter int IFMAP_DEPTH = 16,
  parameter int FILTER_MAX  = 8,
  parameter int NUM_FILT    = 2,
  localparam int FS_W  = $clog2(FILTER_MAX + 1),
  localparam int LEN_W = $clog2(IFMAP_DEPTH + 1),
  localparam int NF_W  = $clog2(NUM_FILT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FS_W-1:0]   filter_size,
  input  logic [LEN_W-1:0]  ifmap_len,
  input  logic [LEN_W-1:0]  stride,
  input  logic [NF_W-1:0]   num_filt,
  input  logic [DATA_W-1:0] ifmap_data,
  input  logic              ifmap_valid,
  output logic              ifmap_ready,
  input  logic [DATA_W-1:0] filter_data,
  input  logic              filter_valid,
  output logic              filter_ready,
  input  logic [ACC_W-1:0]  psum_in_data,
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int FA_W = $clog2(NUM_FILT * FILTER_MAX);
  localparam int IA_W = $clog2(IFMAP_DEPTH);

  state_e state_q, state_d;
  cfg_t   cfg_q, cfg_d;

  logic [FS_W-1:0]  k_q, k_d;
  logic [NF_W-1:0]  f_q, f_d;
  logic [LEN_W-1:0] base_q, base_d;
  logic             err_q, err_d;

  logic [DATA_W-1:0] filt_mem  [NUM_FILT*FILTER_MAX];
  logic [DATA_W-1:0] ifmap_mem [IFMAP_DEPTH];

  logic [FA_W-1:0] filt_addr;
  logic [IA_W-1:0] ifmap_waddr;
  logic [IA_W-1:0] ifmap_raddr;

  logic filt_beat, ifmap_beat, psum_beat, out_beat;
  logic cfg_bad;
  logic last_tap, last_filt, last_pos, last_word;
  logic mac_clr, mac_en, mac_psum;
  logic signed [ACC_W-1:0] acc;

  assign filter_ready = (state_q == LOAD_FILT);
  assign ifmap_ready  = (state_q == LOAD_IFMAP);
  assign out_valid    = (state_q == EMIT);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign err          = err_q;
  assign out_data     = out_valid ? acc : '0;

  assign filt_beat  = filter_valid & filter_ready;
  assign ifmap_beat = ifmap_valid & ifmap_ready;
  assign out_beat   = out_valid & out_ready;

`ifdef PE_CONV1D_PSUM_IN_EN
  assign psum_in_ready = (state_q == ACC_PSUM);
  assign psum_beat     = psum_in_valid & psum_in_ready;
`else
  logic unused_psum;
  assign unused_psum   = ^{psum_in_data, psum_in_valid};
  assign psum_in_ready = 1'b0;
  assign psum_beat     = 1'b0;
`endif

  // the same (f,k) counters address filters on load and on MAC
  assign filt_addr =
    FA_W'(int'(f_q) * FILTER_MAX + int'(k_q));
  assign ifmap_waddr = IA_W'(base_q);
  assign ifmap_raddr =
    IA_W'(int'(base_q) + int'(k_q));

  // job legality and loop-end flags
  always_comb begin
    cfg_bad = (filter_size == '0)
      || (int'(filter_size) > FILTER_MAX)
      || (stride == '0)
      || (num_filt == '0)
      || (int'(num_filt) > NUM_FILT)
      || (int'(ifmap_len) > IFMAP_DEPTH)
      || (int'(ifmap_len) < int'(filter_size));
    last_tap  = (int'(k_q) + 1
      == int'(cfg_q.filter_size));
    last_filt = (int'(f_q) + 1
      == int'(cfg_q.num_filt));
    last_word = (int'(base_q) + 1
      == int'(cfg_q.ifmap_len));
    last_pos  = (int'(base_q)
      + int'(cfg_q.stride)
      + int'(cfg_q.filter_size)
      > int'(cfg_q.ifmap_len));
  end

  // scratchpad writes; contents are reloaded by every job
  always_ff @(posedge clk) begin
    if (filt_beat)  filt_mem[filt_addr]    <= filter_data;
    if (ifmap_beat) ifmap_mem[ifmap_waddr] <= ifmap_data;
  end

  // next-state, counters and MAC control
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    k_d      = k_q;
    f_d      = f_q;
    base_d   = base_q;
    err_d    = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_psum = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            cfg_d.filter_size = filter_size;
            cfg_d.ifmap_len   = ifmap_len;
            cfg_d.stride      = stride;
            cfg_d.num_filt    = num_filt;
            k_d     = '0;
            f_d     = '0;
            base_d  = '0;
            state_d = LOAD_FILT;
          end
        end
      end
      LOAD_FILT: begin
        if (filt_beat) begin
          if (last_tap) begin
            k_d = '0;
            if (last_filt) begin
              f_d     = '0;
              state_d = LOAD_IFMAP;
            end else begin
              f_d = f_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      LOAD_IFMAP: begin
        if (ifmap_beat) begin
          if (last_word) begin
            base_d  = '0;
            state_d = MAC;
          end else begin
            base_d = base_q + 1'b1;
          end
        end
      end
      MAC: begin
        mac_en  = 1'b1;
        mac_clr = (k_q == '0);
        if (last_tap) begin
          k_d = '0;
`ifdef PE_CONV1D_PSUM_IN_EN
          state_d = ACC_PSUM;
`else
          state_d = EMIT;
`endif
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ACC_PSUM: begin
        if (psum_beat) begin
          mac_en   = 1'b1;
          mac_psum = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (out_beat) begin
          if (last_filt) begin
            f_d = '0;
            if (last_pos) begin
              state_d = FIN;
            end else begin
              base_d  = base_q + cfg_q.stride;
              state_d = MAC;
            end
          end else begin
            f_d     = f_q + 1'b1;
            state_d = MAC;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      k_q     <= '0;
      f_q     <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      k_q     <= k_d;
      f_q     <= f_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  pe_mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .add_psum(mac_psum),
    .a       (ifmap_mem[ifmap_raddr]),
    .b       (filt_mem[filt_addr]),
    .psum    (psum_in_data),
    .acc     (acc)
  );

endmodule

// File: tb/tb_pe_conv1d_mc.sv
// Directed self-checking bench for pe_conv1d_mc.
// Define PE_CONV1D_PSUM_IN_EN to also exercise psum accumulation.
module tb_pe_conv1d_mc;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        filter_size;
  logic [4:0]        ifmap_len;
  logic [4:0]        stride;
  logic [1:0]        num_filt;
  logic [7:0]        ifmap_data;
  logic              ifmap_valid;
  logic              ifmap_ready;
  logic [7:0]        filter_data;
  logic              filter_valid;
  logic              filter_ready;
  logic [19:0]       psum_in_data;
  logic              psum_in_valid;
  logic              psum_in_ready;
  logic signed [19:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  always #5 clk = ~clk;

  pe_conv1d_mc dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .filter_size  (filter_size),
    .ifmap_len    (ifmap_len),
    .stride       (stride),
    .num_filt     (num_filt),
    .ifmap_data   (ifmap_data),
    .ifmap_valid  (ifmap_valid),
    .ifmap_ready  (ifmap_ready),
    .filter_data  (filter_data),
    .filter_valid (filter_valid),
    .filter_ready (filter_ready),
    .psum_in_data (psum_in_data),
    .psum_in_valid(psum_in_valid),
    .psum_in_ready(psum_in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int fs, input int len,
                           input int st, input int nf);
    filter_size = 4'(fs);
    ifmap_len   = 5'(len);
    stride      = 5'(st);
    num_filt    = 2'(nf);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_filt(input int v);
    int n = 0;
    filter_data  = 8'(v);
    filter_valid = 1'b1;
    while (!filter_ready && n < 20) begin
      tick();
      n++;
    end
    if (!filter_ready) chk("filt_ready_timeout", 0, 1);
    tick();
    filter_valid = 1'b0;
  endtask

  task automatic send_ifmap(input int v);
    int n = 0;
    ifmap_data  = 8'(v);
    ifmap_valid = 1'b1;
    while (!ifmap_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ifmap_ready) chk("ifmap_ready_timeout", 0, 1);
    tick();
    ifmap_valid = 1'b0;
  endtask

  task automatic get_out(input string tag, input int exp,
                         output int wait_cyc);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    wait_cyc = n;
    chk(tag, out_data, exp);
    tick();
  endtask

  task automatic run_basic(input string tag);
    start_job(3, 5, 1, 1);
    send_filt(1); send_filt(2); send_filt(3);
    for (int i = 1; i <= 5; i++) send_ifmap(i);
    get_out({tag, "_r0"}, 14, lat);
    chk({tag, "_lat0"}, lat, 3);
    get_out({tag, "_r1"}, 20, lat);
    chk({tag, "_lat1"}, lat, 3);
    get_out({tag, "_r2"}, 26, lat);
    chk({tag, "_lat2"}, lat, 3);
    chk({tag, "_done"}, done, 1);
    tick();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    filter_size = '0;
    ifmap_len = '0;
    stride = '0;
    num_filt = '0;
    ifmap_data = '0;
    ifmap_valid = 1'b0;
    filter_data = '0;
    filter_valid = 1'b0;
    psum_in_data = '0;
    psum_in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ifmap_ready", ifmap_ready, 0);
    chk("rst_filter_ready", filter_ready, 0);
    chk("rst_psum_ready", psum_in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    run_basic("basic");

    start_job(3, 7, 2, 1);
    chk("stride_busy", busy, 1);
    chk("stride_fready", filter_ready, 1);
    for (int i = 0; i < 3; i++) send_filt(1);
    for (int i = 1; i <= 7; i++) send_ifmap(i);
`ifndef PE_CONV1D_PSUM_IN_EN
    chk("psum_ready_tied", psum_in_ready, 0);
`endif
    get_out("stride_r0", 6, lat);
    get_out("stride_r1", 12, lat);
    get_out("stride_r2", 18, lat);
    chk("stride_done", done, 1);
    tick();

    start_job(2, 3, 1, 2);
    send_filt(1); send_filt(0);
    send_filt(0); send_filt(-1);
    send_ifmap(3); send_ifmap(5); send_ifmap(7);
    get_out("twof_r0", 3, lat);
    get_out("twof_r1", -5, lat);
    get_out("twof_r2", 5, lat);
    get_out("twof_r3", -7, lat);
    chk("twof_done", done, 1);
    tick();

    out_ready = 1'b0;
    start_job(1, 1, 1, 1);
    send_filt(-128);
    send_ifmap(-128);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        tick();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 16384);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_done", done, 1);
    chk("stall_no_dup", out_valid, 0);
    tick();

    start_job(0, 5, 1, 1);
    chk("err_fs0", err, 1);
    chk("err_fs0_busy", busy, 0);
    tick();
    chk("err_fs0_pulse", err, 0);
    chk("err_fs0_idle", busy, 0);
    start_job(3, 2, 1, 1);
    chk("err_short", err, 1);
    chk("err_short_busy", busy, 0);
    tick();

    start_job(3, 5, 1, 1);
    send_filt(1); send_filt(2); send_filt(3);
    for (int i = 1; i <= 5; i++) send_ifmap(i);
    tick();
    chk("mid_mac_busy", busy, 1);
    rst = 1'b1;
    #2;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    run_basic("after_rst");

`ifdef PE_CONV1D_PSUM_IN_EN
    start_job(3, 5, 1, 1);
    send_filt(1); send_filt(2); send_filt(3);
    for (int i = 1; i <= 5; i++) send_ifmap(i);
    for (int r = 0; r < 3; r++) begin
      int n = 0;
      while (!psum_in_ready && n < 50) begin
        tick();
        n++;
      end
      repeat (3) tick();
      chk("psum_stall_ready", psum_in_ready, 1);
      chk("psum_stall_valid", out_valid, 0);
      psum_in_data  = 20'((r + 1) * 100);
      psum_in_valid = 1'b1;
      tick();
      psum_in_valid = 1'b0;
      get_out("psum_res", 14 + 6 * r + 100 * (r + 1), lat);
    end
    chk("psum_done", done, 1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_conv1d_mc.md
PE_CONV1D_MC -- requirements
Module: pe_conv1d_mc

Interface
REQ-001 Parameter DATA_W, default 8, signed ifmap/filter word width.
REQ-002 Parameter ACC_W, default 20, signed accumulator/output width.
REQ-003 Parameter IFMAP_DEPTH, default 16, ifmap scratchpad entries.
REQ-004 Parameter FILTER_MAX, default 8, maximum taps per filter.
REQ-005 Parameter NUM_FILT, default 2, filter (output channel) slots.
REQ-006 Derived widths: FS_W=$clog2(FILTER_MAX+1), LEN_W=$clog2(IFMAP_DEPTH+1), NF_W=$clog2(NUM_FILT+1).
REQ-007 Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request.
- filter_size  in  FS_W  taps per filter.
- ifmap_len  in  LEN_W  ifmap words.
- stride  in  LEN_W  window step.
- num_filt  in  NF_W  active filters.
- ifmap_data / ifmap_valid / ifmap_ready  in / in / out  DATA_W / 1 / 1  ifmap stream.
- filter_data / filter_valid / filter_ready  in / in / out  DATA_W / 1 / 1  filter stream.
- psum_in_data / psum_in_valid / psum_in_ready  in / in / out  ACC_W / 1 / 1  incoming psum stream.
- out_data / out_valid / out_ready  out / out / in  ACC_W / 1 / 1  result stream.
- busy / done / err  out  1 each  status.

Function
REQ-008 FSM states: IDLE, LOAD_FILT, LOAD_IFMAP, MAC, ACC_PSUM, EMIT, FIN.
REQ-009 IDLE: start latches all config inputs; config is illegal if filter_size is 0 or >FILTER_MAX, stride is 0, num_filt is 0 or >NUM_FILT, ifmap_len >IFMAP_DEPTH, or ifmap_len <filter_size.
REQ-010 Illegal config: err high for exactly one cycle, FSM stays in IDLE, busy stays 0; legal config: next state LOAD_FILT.
REQ-011 start outside IDLE is ignored; busy=1 in every non-IDLE state.
REQ-012 Stream beat occurs when valid and ready are high in the same cycle; ready is combinational from state only, never from valid.
REQ-013 LOAD_FILT: filter_ready=1; accepts num_filt*filter_size beats, filter-major then tap order; filter f tap k is stored at f*FILTER_MAX+k; moves to LOAD_IFMAP after the last beat.
REQ-014 LOAD_IFMAP: ifmap_ready=1; accepts ifmap_len beats into addresses 0..ifmap_len-1; moves to MAC after the last beat.
REQ-015 Output count N=(ifmap_len-filter_size)/stride+1 (integer division); results are ordered position-major, filter-minor.
REQ-016 MAC: one tap per cycle, acc += sext(ifmap[p*stride+k]*filter[f][k]) for k=0..filter_size-1; acc is cleared at the first tap; filter_size cycles per result.
REQ-017 Arithmetic is two's complement; product is 2*DATA_W bits, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W with no saturation.
REQ-018 EMIT: out_valid=1 with out_data=acc; both are held stable until out_ready; after the handshake the FSM goes to MAC for the next (p,f), or to FIN after result N*num_filt.
REQ-019 FIN: done high for exactly one cycle, then IDLE.
REQ-020 Minimum latency per result is filter_size+1 cycles with out_ready tied high.

Reset
REQ-021 rst asserted at any time forces IDLE immediately and drops any job in progress.
REQ-022 Reset values: out_data=0; out_valid, ifmap_ready, filter_ready, psum_in_ready, busy, done and err all 0; all counters and acc 0.
REQ-023 Scratchpad contents are not reset; every job reloads them before use.

Configuration
REQ-024 Macro PE_CONV1D_PSUM_IN_EN defined: after the MAC state for each result, the FSM enters ACC_PSUM; psum_in_ready=1 there; on the beat, acc += psum_in_data (modulo 2^ACC_W); then EMIT.
REQ-025 Macro undefined: ACC_PSUM is unreachable (MAC goes directly to EMIT); psum_in_ready is tied 0; psum_in_data and psum_in_valid are ignored; all ports remain present.

Structure
REQ-026 Package pe_conv1d_pkg holds the state enum, the derived-width localparams and a packed config struct (filter_size, ifmap_len, stride, num_filt).
REQ-027 One sub-module, pe_mac_unit: signed multiply plus ACC_W accumulator register with clear and enable inputs, same clk/rst.

Verification
REQ-028 Basic job: fs=3, stride=1, len=5, nf=1, filter {1,2,3}, ifmap {1,2,3,4,5} -> out 14, 20, 26, then done pulses once.
REQ-029 Stride: fs=3, stride=2, len=7, filter {1,1,1}, ifmap 1..7 -> out 6, 12, 18.
REQ-030 Two filters: fs=2, nf=2, filters {1,0} and {0,-1}, ifmap {3,5,7} -> out 3, -5, 5, -7 in that order.
REQ-031 Backpressure and signed boundary:
- out_ready held low 5 cycles -> out_valid and out_data stable for the full stall; no result lost or duplicated.
- DATA_W=8, filter {-128}, ifmap {-128} -> out 16384.
REQ-032 Error and reset:
- fs=0 -> err for 1 cycle, busy stays 0.
- rst asserted mid-MAC -> all outputs 0 immediately; a subsequent legal job completes correctly.
REQ-033 With PE_CONV1D_PSUM_IN_EN defined, REQ-028 stimulus plus psum_in {100, 200, 300} -> out 114, 220, 326; psum_in_valid held low stalls each result in ACC_PSUM.
